// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and baud divisor helper
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP,
    S_WAIT_HIGH = ST_WAIT_HIGH
  } uart_state_e;

  // Integer division: any fractional remainder becomes baud error absorbed by mid-bit sampling.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - double-flop synchronizer with a selectable reset level
// Resets to the line's idle level so a reset never looks like a start bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, framing check and break lockout
// Delivers each good byte with a one-cycle rx_valid; a low stop bit gives one frame_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 10_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic w_rx_s;

  uart_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_sh;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_rx_busy;

  uart_state_e          w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [2:0]           w_bit_idx_nxt;
  logic [DATA_BITS-1:0] w_sh_nxt;
  logic [DATA_BITS-1:0] w_rx_data_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_frame_err_nxt;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync_rxd (
    .clk  (clk),
    .reset(reset),
    .i_d  (uart_rxd),
    .o_q  (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_bit_idx   <= 3'd0;
      r_sh        <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_busy   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_sh        <= w_sh_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      // Tracks the state being entered, so busy drops in the same cycle valid rises.
      r_rx_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_sh_nxt        = r_sh;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_ZERO;
        end
      end

      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = CNT_ZERO;
          // A start bit that is no longer low at its centre is treated as line noise.
          if (!w_rx_s) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_sh_nxt  = {w_rx_s, r_sh[DATA_BITS-1:1]};
          w_cnt_nxt = CNT_ZERO;
          if (r_bit_idx == IDX_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = CNT_ZERO;
          if (w_rx_s) begin
            w_rx_data_nxt  = r_sh;
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_busy   = r_rx_busy;
  assign frame_err = r_frame_err;

endmodule
